// File: rtl/traffic_analyzer_pkg.sv
// Shared constants, status encoding and FSM states for the GMII receive traffic analyzer.
`timescale 1ns/1ps
package traffic_analyzer_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        StatusGood   = 2'd0,
        StatusBadFcs = 2'd1,
        StatusError  = 2'd2
    } frame_status_e;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StData,
        StDrop
    } state_e;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational Ethernet CRC-32 step for one byte, LSB-first (reflected) bit order.
`timescale 1ns/1ps
module eth_crc32_d8
    import traffic_analyzer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] PolyRefl = reflect32(CRC_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ PolyRefl) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/traffic_analyzer_gmii.sv
// GMII receive frame checker: delineates frames, checks FCS and length, keeps live
// statistics counters plus a shadow copy that software reads coherently.
`timescale 1ns/1ps
module traffic_analyzer_gmii
    import traffic_analyzer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           gmii_rxd,
    input  logic                 gmii_rx_dv,
    input  logic                 gmii_rx_er,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 snapshot,
    output logic [CNT_WIDTH-1:0] good_frames,
    output logic [CNT_WIDTH-1:0] bad_fcs_frames,
    output logic [CNT_WIDTH-1:0] error_frames,
    output logic [CNT_WIDTH-1:0] good_bytes,
    output logic                 frame_done,
    output logic [15:0]          frame_len,
    output logic [1:0]           frame_status
);

    localparam logic [15:0]          MinLen = 16'(MIN_LEN);
    localparam logic [15:0]          MaxLen = 16'(MAX_LEN);
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [7:0] rxd_q;
    logic       dv_q, er_q, en_q;

    // Deliberately not reset: the copy keeps tracking the line during reset so a frame
    // in progress at reset release is seen as such and ignored until dv drops.
    always_ff @(posedge clk) begin
        rxd_q <= gmii_rxd;
        dv_q  <= gmii_rx_dv;
        er_q  <= gmii_rx_er;
        en_q  <= enable;
    end

    state_e        state_q;
    logic          armed_q;
    logic [15:0]   len_q;
    logic [31:0]   crc_q, crc_next;
    logic          err_q, count_this_q, drop_err_q;
    logic          done_q;
    logic [15:0]   frame_len_q;
    frame_status_e status_q;

    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (rxd_q),
        .crc_out (crc_next)
    );

    logic          frame_end, drop_end;
    frame_status_e end_status;

    always_comb begin
        frame_end = (state_q == StData) && !dv_q;
        drop_end  = (state_q == StDrop) && !dv_q && drop_err_q;
        if (err_q || (len_q < MinLen) || (len_q > MaxLen)) begin
            end_status = StatusError;
        end else if (crc_q != CRC_RESIDUE) begin
            end_status = StatusBadFcs;
        end else begin
            end_status = StatusGood;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            armed_q      <= 1'b0;
            len_q        <= '0;
            crc_q        <= CRC_INIT;
            err_q        <= 1'b0;
            count_this_q <= 1'b0;
            drop_err_q   <= 1'b0;
            done_q       <= 1'b0;
            frame_len_q  <= '0;
            status_q     <= StatusGood;
        end else begin
            done_q <= 1'b0;
            if (!dv_q) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    len_q <= '0;
                    crc_q <= CRC_INIT;
                    err_q <= 1'b0;
                    if (dv_q && armed_q) begin
                        if (rxd_q == PREAMBLE_BYTE) begin
                            state_q <= StPreamble;
                        end else if (rxd_q == SFD_BYTE) begin
                            state_q      <= StData;
                            count_this_q <= en_q;
                        end else begin
                            state_q      <= StDrop;
                            drop_err_q   <= 1'b1;
                            count_this_q <= en_q;
                        end
                    end
                end
                StPreamble: begin
                    if (!dv_q) begin
                        state_q <= StIdle;
                    end else if (rxd_q == SFD_BYTE) begin
                        state_q      <= StData;
                        count_this_q <= en_q;
                    end else if (rxd_q != PREAMBLE_BYTE) begin
                        state_q      <= StDrop;
                        drop_err_q   <= 1'b1;
                        count_this_q <= en_q;
                    end
                end
                StData: begin
                    if (dv_q) begin
                        crc_q <= crc_next;
                        if (len_q != 16'hFFFF) begin
                            len_q <= len_q + 16'd1;
                        end
                        if (er_q) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        state_q     <= StIdle;
                        frame_len_q <= len_q;
                        status_q    <= end_status;
                        done_q      <= count_this_q;
                    end
                end
                StDrop: begin
                    if (!dv_q) begin
                        state_q    <= StIdle;
                        drop_err_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [CNT_WIDTH-1:0] good_q, bad_q, errc_q, bytes_q;
    logic [CNT_WIDTH-1:0] good_s_q, bad_s_q, errc_s_q, bytes_s_q;

    // Shadow copies read the pre-update live values, and clear overrides any coincident
    // frame-end update.
    always_ff @(posedge clk) begin
        if (reset) begin
            good_q    <= '0;
            bad_q     <= '0;
            errc_q    <= '0;
            bytes_q   <= '0;
            good_s_q  <= '0;
            bad_s_q   <= '0;
            errc_s_q  <= '0;
            bytes_s_q <= '0;
        end else begin
            if (snapshot) begin
                good_s_q  <= good_q;
                bad_s_q   <= bad_q;
                errc_s_q  <= errc_q;
                bytes_s_q <= bytes_q;
            end
            if (clear) begin
                good_q  <= '0;
                bad_q   <= '0;
                errc_q  <= '0;
                bytes_q <= '0;
            end else if (count_this_q) begin
                if (frame_end) begin
                    case (end_status)
                        StatusGood: begin
                            good_q  <= good_q + CntOne;
                            bytes_q <= bytes_q + CNT_WIDTH'(len_q);
                        end
                        StatusBadFcs: bad_q  <= bad_q + CntOne;
                        default:      errc_q <= errc_q + CntOne;
                    endcase
                end else if (drop_end) begin
                    errc_q <= errc_q + CntOne;
                end
            end
        end
    end

    assign good_frames    = good_s_q;
    assign bad_fcs_frames = bad_s_q;
    assign error_frames   = errc_s_q;
    assign good_bytes     = bytes_s_q;
    assign frame_done     = done_q;
    assign frame_len      = frame_len_q;
    assign frame_status   = status_q;

endmodule

// File: tb/tb_traffic_analyzer_gmii.sv
// Self-checking bench for traffic_analyzer_gmii: directed table, corner sequences and
// randomized frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_traffic_analyzer_gmii;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int         pre;
        int         len;
        bit         bad;
        int         er_pos;
        logic [1:0] exp_status;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, gmii_rx_dv, gmii_rx_er, enable, clear, snapshot;
    logic [7:0]  gmii_rxd;
    logic [63:0] good_frames, bad_fcs_frames, error_frames, good_bytes;
    logic        frame_done;
    logic [15:0] frame_len;
    logic [1:0]  frame_status;

    always #4 clk = ~clk;

    traffic_analyzer_gmii #(
        .CNT_WIDTH (64),
        .MIN_LEN   (64),
        .MAX_LEN   (1518)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .gmii_rxd       (gmii_rxd),
        .gmii_rx_dv     (gmii_rx_dv),
        .gmii_rx_er     (gmii_rx_er),
        .enable         (enable),
        .clear          (clear),
        .snapshot       (snapshot),
        .good_frames    (good_frames),
        .bad_fcs_frames (bad_fcs_frames),
        .error_frames   (error_frames),
        .good_bytes     (good_bytes),
        .frame_done     (frame_done),
        .frame_len      (frame_len),
        .frame_status   (frame_status)
    );

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [15:0] last_len;
    logic [1:0]  last_status;
    logic [63:0] exp_good, exp_bad, exp_err, exp_bytes;

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt    = done_cnt + 1;
            last_len    = frame_len;
            last_status = frame_status;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] d, input logic v, input logic e);
        gmii_rxd   = d;
        gmii_rx_dv = v;
        gmii_rx_er = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0);
    endtask

    // Standard bitwise LSB-first CRC-32 over the first n bytes.
    function automatic logic [31:0] crc_bytes(input bq_t q, input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_frame(input int len, input bit bad, input bit rnd, output bq_t q);
        logic [31:0] fcs;
        q = {};
        for (int i = 0; i < len - 4; i++) q.push_back(rnd ? 8'($urandom) : 8'(i + 1));
        fcs = ~crc_bytes(q, len - 4);
        for (int i = 0; i < 4; i++) q.push_back(fcs[8*i +: 8]);
        if (bad) q[len-1] = q[len-1] ^ 8'hFF;
    endtask

    task automatic send(input int pre, input bq_t q, input int er_pos, input int tog_pos,
                        input int ifg);
        for (int i = 0; i < pre; i++) cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            if (i == tog_pos) enable = ~enable;
            cyc(q[i], 1'b1, i == er_pos);
        end
        idle(ifg);
    endtask

    // Classification from the frame's own contents: received FCS vs CRC of the payload.
    function automatic logic [1:0] model_status(input bq_t q, input bit er);
        int          n = q.size();
        logic [31:0] fcs_rx;
        if (er || n < 64 || n > 1518) return 2'd2;
        fcs_rx = {q[n-1], q[n-2], q[n-3], q[n-4]};
        if (~crc_bytes(q, n - 4) != fcs_rx) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_count(input logic [1:0] st, input int len);
        case (st)
            2'd0: begin exp_good++; exp_bytes = exp_bytes + 64'(len); end
            2'd1: exp_bad++;
            default: exp_err++;
        endcase
    endtask

    task automatic model_zero();
        exp_good = 0; exp_bad = 0; exp_err = 0; exp_bytes = 0;
    endtask

    task automatic snap_check(input string tag);
        snapshot = 1'b1;
        @(posedge clk);
        #1;
        snapshot = 1'b0;
        check({tag, "_good"},  good_frames,    exp_good);
        check({tag, "_badfcs"}, bad_fcs_frames, exp_bad);
        check({tag, "_err"},   error_frames,   exp_err);
        check({tag, "_bytes"}, good_bytes,     exp_bytes);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_zero();
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 8 && done_cnt < target; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(done_cnt), 64'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    vec_t        vecs[9];
    bq_t         q;
    logic [1:0]  st;
    logic [63:0] pre_good;
    int          base;

    initial begin
        vecs[0] = '{7, 64,   1'b0, -1, 2'd0};
        vecs[1] = '{7, 64,   1'b1, -1, 2'd1};
        vecs[2] = '{7, 64,   1'b0, 20, 2'd2};
        vecs[3] = '{7, 40,   1'b0, -1, 2'd2};
        vecs[4] = '{7, 63,   1'b0, -1, 2'd2};
        vecs[5] = '{0, 64,   1'b0, -1, 2'd0};
        vecs[6] = '{3, 1518, 1'b0, -1, 2'd0};
        vecs[7] = '{7, 1519, 1'b0, -1, 2'd2};
        vecs[8] = '{1, 65,   1'b1, -1, 2'd1};

        reset = 1'b1; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        enable = 1'b1; clear = 1'b0; snapshot = 1'b0;
        model_zero();
        repeat (3) @(posedge clk);
        #1;
        check("rst_good",   good_frames,    64'd0);
        check("rst_badfcs", bad_fcs_frames, 64'd0);
        check("rst_err",    error_frames,   64'd0);
        check("rst_bytes",  good_bytes,     64'd0);
        check("rst_done",   64'(frame_done),   64'd0);
        check("rst_len",    64'(frame_len),    64'd0);
        check("rst_status", 64'(frame_status), 64'd0);
        reset = 1'b0;
        idle(2);

        for (int v = 0; v < 9; v++) begin
            build_frame(vecs[v].len, vecs[v].bad, 1'b0, q);
            send(vecs[v].pre, q, vecs[v].er_pos, -1, 1);
            model_count(model_status(q, vecs[v].er_pos >= 0), vecs[v].len);
            exp_done++;
            wait_done(exp_done, $sformatf("vec%0d_done", v));
            check($sformatf("vec%0d_len", v), 64'(last_len), 64'(vecs[v].len));
            check($sformatf("vec%0d_status", v), 64'(last_status), 64'(vecs[v].exp_status));
            idle(2);
            snap_check($sformatf("vec%0d", v));
        end

        // Bad preamble byte: dropped, counted as error, no frame_done.
        cyc(8'h55, 1'b1, 1'b0);
        cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hAB, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(8'($urandom), 1'b1, 1'b0);
        idle(4);
        exp_err++;
        check("prerr_no_done", 64'(done_cnt), 64'(exp_done));
        snap_check("prerr");
        build_frame(64, 1'b0, 1'b1, q);
        send(7, q, -1, -1, 1);
        model_count(model_status(q, 1'b0), 64);
        exp_done++;
        wait_done(exp_done, "prerr_recover_done");
        check("prerr_recover_status", 64'(last_status), 64'd0);
        idle(2);

        // Ten back-to-back frames, clear on the 5th frame_done.
        model_zero();
        base = done_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    build_frame(64, 1'b0, 1'b0, q);
                    send(7, q, -1, -1, 1);
                    if (i >= 5) model_count(model_status(q, 1'b0), 64);
                end
            end
            begin
                for (int i = 0; i < 3000 && done_cnt < base + 5; i++) @(negedge clk);
                if (done_cnt == base + 5) begin
                    clear = 1'b1;
                    @(posedge clk);
                    #1;
                    clear = 1'b0;
                end
            end
        join
        exp_done = base + 10;
        wait_done(exp_done, "b2b_done");
        idle(2);
        snap_check("b2b");

        // Snapshot on the same edge as the frame-end update sees pre-update values.
        build_frame(64, 1'b0, 1'b1, q);
        pre_good = exp_good;
        send(7, q, -1, -1, 1);
        snapshot = 1'b1;
        @(posedge clk);
        #1;
        snapshot = 1'b0;
        check("snapcoinc_pre_good", good_frames, pre_good);
        model_count(model_status(q, 1'b0), 64);
        exp_done++;
        wait_done(exp_done, "snapcoinc_done");
        idle(2);
        snap_check("snapcoinc_post");

        // Clear on the same edge as the frame-end update: frame not counted.
        build_frame(64, 1'b0, 1'b1, q);
        send(7, q, -1, -1, 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_zero();
        idle(4);
        exp_done = done_cnt;
        snap_check("clrcoinc");

        // Enable off for frames 1-3, raised mid-frame 4, on for frame 5.
        pulse_clear();
        base = done_cnt;
        for (int f = 0; f < 5; f++) begin
            enable = (f == 4);
            build_frame(64, 1'b0, 1'b0, q);
            send(7, q, -1, (f == 3) ? 30 : -1, 1);
            if (f == 4) model_count(model_status(q, 1'b0), 64);
        end
        idle(4);
        exp_done = base + 1;
        check("en_done", 64'(done_cnt), 64'(exp_done));
        snap_check("en_a");
        #5000;
        snap_check("en_b");

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            int len, er_pos, pre, ifg;
            bit bad, en;
            len    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 63))
                                                 : int'($urandom_range(64, 200));
            bad    = ($urandom_range(0, 3) == 0);
            er_pos = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            en     = ($urandom_range(0, 3) != 0);
            pre    = int'($urandom_range(0, 7));
            ifg    = int'($urandom_range(1, 3));
            enable = en;
            build_frame(len, bad, 1'b1, q);
            send(pre, q, er_pos, -1, ifg);
            st = model_status(q, er_pos >= 0);
            if (en) begin
                model_count(st, len);
                exp_done++;
                wait_done(exp_done, $sformatf("rnd%0d_done", f));
                check($sformatf("rnd%0d_len", f), 64'(last_len), 64'(len));
                check($sformatf("rnd%0d_status", f), 64'(last_status), 64'(st));
            end
        end
        enable = 1'b1;
        idle(4);
        check("rnd_done_total", 64'(done_cnt), 64'(exp_done));
        snap_check("rnd");

        // Reset mid-frame; the remainder of that frame is ignored.
        for (int i = 0; i < 7; i++) cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) cyc(8'($urandom), 1'b1, 1'b0);
        reset = 1'b1;
        cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hD5, 1'b1, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cyc(8'hD5, 1'b1, 1'b0);
        idle(4);
        model_zero();
        check("rstmid_no_done", 64'(done_cnt), 64'(exp_done));
        check("rstmid_len", 64'(frame_len), 64'd0);
        snap_check("rstmid");
        build_frame(64, 1'b0, 1'b1, q);
        send(7, q, -1, -1, 1);
        model_count(model_status(q, 1'b0), 64);
        exp_done++;
        wait_done(exp_done, "rstmid_recover_done");
        idle(2);
        snap_check("rstmid_recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_analyzer_gmii.md
# traffic_analyzer_gmii

Receive-side GMII frame checker. It sits directly downstream of the GMII mux and observes the byte stream that the traffic generator (or a MAC) drives onto a port. It delineates frames on preamble/SFD, checks FCS and length, and keeps 64-bit frame and byte counters. A snapshot shadow copy of the counters lets software read the low and high words coherently.

## Interface

Parameters:
- CNT_WIDTH, 64: width of every statistics counter
- MIN_LEN, 64: minimum legal frame length in bytes, DA through FCS
- MAX_LEN, 1518: maximum legal frame length in bytes, DA through FCS

Ports:
- clk  in  1  GMII receive clock (125 MHz); the single clock of the block
- reset  in  1  synchronous, active-high reset
- gmii_rxd  in  8  receive data
- gmii_rx_dv  in  1  receive data valid
- gmii_rx_er  in  1  receive error
- enable  in  1  counting enable, sampled at SFD
- clear  in  1  one-cycle pulse that zeroes the live counters
- snapshot  in  1  one-cycle pulse that copies live counters to the shadow outputs
- good_frames  out  CNT_WIDTH  shadow count of good frames
- bad_fcs_frames  out  CNT_WIDTH  shadow count of frames with bad FCS and legal length
- error_frames  out  CNT_WIDTH  shadow count of frames with rx_er, runt/giant length, or bad preamble
- good_bytes  out  CNT_WIDTH  shadow sum of good-frame lengths
- frame_done  out  1  one-cycle pulse per counted frame
- frame_len  out  16  length of the last frame, DA through FCS, saturating at 0xFFFF
- frame_status  out  2  status of the last frame: 0 good, 1 bad FCS, 2 error

## Operation

- **FSM states:** IDLE, PREAMBLE, DATA, DROP.
- **IDLE:**
  - dv=1 and rxd=0x55 → PREAMBLE.
  - dv=1 and rxd=0xD5 → DATA. A frame with no preamble is accepted.
  - dv=1 with any other rxd → DROP, flagged as an error.
- **PREAMBLE:**
  - rxd=0x55 → stay.
  - rxd=0xD5 → DATA. `enable` is latched into `count_this` at this point.
  - Any other rxd → DROP, flagged as an error.
  - dv=0 → IDLE, nothing counted.
- **DATA:**
  - Each byte with dv=1 updates CRC-32 (reflected, poly 0x04C11DB7, init 0xFFFFFFFF) and increments `len`, saturating.
  - rx_er=1 on any cycle sets a sticky `err` flag.
  - dv=0 ends the frame → IDLE.
- **DROP:** waits for dv=0, then → IDLE. If an error was flagged, it is counted as an error frame, provided `enable` was high when the error was flagged.
- **Frame classification at end of frame, in priority order:**
  - error: `err`, or len<MIN_LEN, or len>MAX_LEN
  - bad FCS: CRC register ≠ residue 0xDEBB20E3
  - good: otherwise
- **Counters:**
  - Live counters update only when `count_this`=1.
  - good_bytes += len.
  - All counters wrap modulo 2^CNT_WIDTH.
- **clear:** zeroes the live counters. If a frame-end update occurs in the same cycle, clear wins and that frame is not counted. Shadow outputs are untouched by clear.
- **snapshot:** shadow ← live. If it coincides with a frame-end update, the snapshot captures the pre-update values.
- **Reset:**
  - All live and shadow counters are 0.
  - frame_len is 0, frame_status is 0, frame_done is 0, FSM is IDLE.
  - A reset in the middle of a frame discards that frame. The block resynchronises on the next dv rising edge only; a frame in progress at reset release is ignored until dv drops.

## Timing

- **Pipeline:** inputs are registered once. The FSM acts on the registered copies.
- **frame_done:** pulses high 2 cycles after the first input cycle with dv=0 following DATA. frame_len, frame_status and the live counters are valid in that same cycle.
- **snapshot latency:** shadow outputs change 1 cycle after the snapshot pulse.
- **Back-to-back frames:** a minimum IFG of 1 idle cycle must be handled with no frame lost.
- **Throughput:** one byte per cycle, sustained. There is no backpressure.

## Structure

- **Package `traffic_analyzer_pkg`:**
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_POLY, CRC_INIT, CRC_RESIDUE
  - status encoding
  - FSM state enum
- **Sub-module `eth_crc32_d8`:** combinational next-CRC for one byte, reflected input.

## Test plan

- Preamble 7×0x55 + 0xD5, then a 64-byte frame with correct FCS (e.g. payload 01..3C, FCS 0x344CA062), enable=1, snapshot → good_frames=1, good_bytes=64, frame_status=0.
- Same frame with the last FCS byte flipped → bad_fcs_frames=1, good_frames unchanged.
- rx_er asserted on byte 20 → error_frames=1. Separately, a 40-byte frame with valid FCS → error_frames increments (runt).
- Preamble 0x55 0x55 0xAB … → error_frames=1, no frame_done, FSM back to IDLE after dv falls.
- 10 good frames with 1-cycle IFG; clear pulsed coincident with the 5th frame_done → after snapshot, good_frames=5 and good_bytes=320.
- enable=0 for frames 1–3 and toggled mid-frame 4, then a snapshot; a second snapshot 5000 ns later with no traffic → only frame 5 onward counted, and both snapshots are identical.
